// File: rtl/scan_mux_reg_if.sv
// Channel inputs, select controls and registered outputs of the scan multiplexer.
// The master side drives the channels and controls; the slave side is the mux itself.
interface scan_mux_reg_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 2
);
  logic [N_CH*DATA_W-1:0] din;
  logic                   mode;
  logic [SEL_W-1:0]       sel_in;
  logic                   load;
  logic                   hold;
  logic [DATA_W-1:0]      dout;
  logic                   dout_vld;
  logic [SEL_W-1:0]       cur_sel;
  logic                   wrap;
  logic                   sel_err;

  modport master (
    output din, mode, sel_in, load, hold,
    input  dout, dout_vld, cur_sel, wrap, sel_err
  );

  modport slave (
    input  din, mode, sel_in, load, hold,
    output dout, dout_vld, cur_sel, wrap, sel_err
  );
endinterface

// File: rtl/scan_mux_reg.sv
// N-channel registered multiplexer. The select is either loaded manually or advanced
// by a dwell counter in auto-scan mode.
module scan_mux_reg #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DWELL  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_mux_reg_if.slave bus
);

  typedef enum logic [0:0] {StManual, StScan} state_e;

  localparam logic [SEL_W-1:0] LastSel   = SEL_W'(N_CH - 1);
  localparam logic [7:0]       LastDwell = 8'(DWELL - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        dwell_q, dwell_d;
  logic [DATA_W-1:0] dout_q, mux_out;
  logic              vld_q, vld_d;
  logic              started_q;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  // Indices at or beyond N_CH never match, so they decode to zero.
  always_comb begin
    mux_out = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_q == SEL_W'(k)) mux_out = bus.din[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = bus.mode ? StScan : StManual;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.mode) begin
      // The entry edge only restarts the dwell; the select is left where it was.
      if (state_q == StManual) begin
        dwell_d = '0;
      end else if (!bus.hold) begin
        if (dwell_q == LastDwell) begin
          dwell_d = '0;
          if (sel_q == LastSel) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
    end else begin
      dwell_d = '0;
      if (bus.load) begin
        if (32'(bus.sel_in) < N_CH) sel_d = bus.sel_in;
        else                        err_d = 1'b1;
      end
    end
    // dout lags the select by one edge, so it is stale for the cycle after a change.
    vld_d = started_q && (sel_d == sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StManual;
      sel_q     <= '0;
      dwell_q   <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      started_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dwell_q   <= dwell_d;
      dout_q    <= mux_out;
      vld_q     <= vld_d;
      started_q <= 1'b1;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.cur_sel  = sel_q;
  assign bus.wrap     = wrap_q;
  assign bus.sel_err  = err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Randomised bench for scan_mux_reg (3 channels, 8 bits, dwell 4) against a
// cycle-level reference model of the select/dwell rules.
module tb_scan_mux_reg;
  localparam int unsigned N_CH   = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DWELL  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  scan_mux_reg_if #(.N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  scan_mux_reg #(
    .N_CH  (N_CH),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ch [N_CH];

  int                m_sel, m_spent, m_wraps, dut_wraps;
  bit                m_scan, m_started, m_vld, m_wrap, m_err;
  logic [DATA_W-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_spent = 0; m_scan = 0; m_started = 0;
    m_vld = 0; m_wrap = 0; m_err = 0; m_dout = '0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step(input bit md, input bit ld, input int si, input bit hd);
    int old_sel;
    old_sel = m_sel;
    m_dout  = (m_sel < int'(N_CH)) ? ch[m_sel] : '0;
    m_wrap  = 0;
    m_err   = 0;
    if (md) begin
      if (!m_scan) begin
        m_spent = 0;
      end else if (!hd) begin
        m_spent++;
        if (m_spent == int'(DWELL)) begin
          m_spent = 0;
          m_wrap  = (m_sel == int'(N_CH) - 1);
          m_sel   = (m_sel + 1) % int'(N_CH);
          if (m_wrap) m_wraps++;
        end
      end
    end else if (ld) begin
      if (si < int'(N_CH)) m_sel = si;
      else                 m_err = 1;
    end
    m_scan    = md;
    m_vld     = m_started && (m_sel == old_sel);
    m_started = 1;
  endtask

  task automatic check_all();
    check("dout",     32'(bus.dout),     32'(m_dout));
    check("dout_vld", 32'(bus.dout_vld), 32'(m_vld));
    check("cur_sel",  32'(bus.cur_sel),  32'(m_sel));
    check("wrap",     32'(bus.wrap),     32'(m_wrap));
    check("sel_err",  32'(bus.sel_err),  32'(m_err));
    if (bus.wrap === 1'b1) dut_wraps++;
  endtask

  // Drive inputs just after a falling edge, advance the model on the rising edge,
  // and compare on the following falling edge.
  task automatic cycle(input bit md, input bit ld, input int si, input bit hd);
    bus.mode   = md;
    bus.load   = ld;
    bus.sel_in = SEL_W'(si);
    bus.hold   = hd;
    for (int k = 0; k < int'(N_CH); k++) bus.din[k*DATA_W +: DATA_W] = ch[k];
    @(posedge clk);
    model_step(md, ld, si, hd);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit md;
    m_wraps   = 0;
    dut_wraps = 0;
    model_reset();
    bus.din = '0; bus.mode = 0; bus.sel_in = '0; bus.load = 0; bus.hold = 0;
    ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'h33;

    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Manual load, out-of-range load, reload of the same channel.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 2, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 3, 0);
    cycle(0, 1, 2, 0);
    cycle(0, 1, 0, 0);

    // Plain scan through two full rotations, with a load that must be ignored.
    for (int i = 0; i < 26; i++) cycle(1, (i == 7), 3, 0);
    // Hold mid-dwell, then drop back to manual and re-enter scan.
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

    md = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_dout", 32'(bus.dout),     32'(0));
        check("rst_vld",  32'(bus.dout_vld), 32'(0));
        check("rst_sel",  32'(bus.cur_sel),  32'(0));
        check("rst_wrap", 32'(bus.wrap),     32'(0));
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int k = 0; k < int'(N_CH); k++) ch[k] = DATA_W'($urandom);
      if ($urandom_range(0, 15) == 0) md = !md;
      cycle(md, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0));
    end

    check("wrap_count", 32'(dut_wraps), 32'(m_wraps));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
